cpu_prog_loader: RTL and testbench



---
 rtl/cpu_prog_loader.sv | 160 ++++++++++++++++
 tb/tb_cpu_prog_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_prog_loader.sv
// Streams 32-bit words into CPU instruction/data memory at auto-incrementing addresses, then releases the CPU and waits for done.
// Optional run-phase watchdog (adds the timeout port): define CPU_PROG_LOADER_WATCHDOG_EN.
module cpu_prog_loader #(
   parameter int ADDR_W         = 10,
   parameter int MEM_DEPTH      = 1024,
   parameter int HOLD_CYCLES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   input  logic              in_is_data,
   input  logic              in_last,
   output logic              cpu_rst,
   output logic [31:0]       inst_data,
   output logic [ADDR_W-1:0] address,
   output logic              write_instruction,
   output logic              write_data,
   input  logic              cpu_done,
   output logic              busy,
   output logic              load_done,
   output logic              ovf_err,
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
   output logic              timeout,
`endif
   output logic [ADDR_W:0]   iword_cnt,
   output logic [ADDR_W:0]   dword_cnt
);
   localparam int CNT_W = ADDR_W + 1;
   localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("cpu_prog_loader: HOLD_CYCLES and TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, DONE} state_t;

   state_t            state, next;
   logic [HW-1:0]     hold_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_is_data, wr_last, wr_ovf;
   logic [CNT_W-1:0]  sel_cnt;
   logic              sel_ovf, hs, hold_end, sess_start;

   assign sel_cnt    = in_is_data ? dword_cnt : iword_cnt;
   assign sel_ovf    = (sel_cnt >= CNT_W'(MEM_DEPTH));
   assign hs         = (state == LOAD) && in_valid;
   assign hold_end   = (state == WRITE) && (hold_cnt == HW'(HOLD_CYCLES - 1));
   assign sess_start = start && ((state == IDLE) || (state == DONE));

`ifdef CPU_PROG_LOADER_WATCHDOG_EN
   localparam int RW = $clog2(TIMEOUT_CYCLES + 1);
   logic [RW-1:0] run_cnt;
   logic          run_to;
   assign run_to = (run_cnt == RW'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      next              = state;
      in_ready          = 1'b0;
      cpu_rst           = 1'b1;
      busy              = 1'b0;
      write_instruction = 1'b0;
      write_data        = 1'b0;
      address           = addr_q;
      case (state)
         IDLE: if (start) next = LOAD;
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            address  = sel_cnt[ADDR_W-1:0];
            if (in_valid) next = WRITE;
         end
         WRITE: begin
            busy              = 1'b1;
            write_instruction = !wr_ovf && !wr_is_data;
            write_data        = !wr_ovf && wr_is_data;
            if (hold_end) next = wr_last ? RUN : LOAD;
         end
         RUN: begin
            busy    = 1'b1;
            cpu_rst = 1'b0;
            if (cpu_done) next = DONE;
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
            else if (run_to) next = DONE;
`endif
         end
         DONE: begin
            // CPU stays out of reset so its registers remain observable, unless the watchdog fired.
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
            cpu_rst = timeout;
`else
            cpu_rst = 1'b0;
`endif
            if (start) next = LOAD;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt   <= '0;
         addr_q     <= '0;
         inst_data  <= '0;
         wr_is_data <= 1'b0;
         wr_last    <= 1'b0;
         wr_ovf     <= 1'b0;
         iword_cnt  <= '0;
         dword_cnt  <= '0;
         load_done  <= 1'b0;
         ovf_err    <= 1'b0;
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
         run_cnt    <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         if (sess_start) begin
            iword_cnt <= '0;
            dword_cnt <= '0;
            load_done <= 1'b0;
            ovf_err   <= 1'b0;
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
            timeout   <= 1'b0;
`endif
         end
         if (hs) begin
            inst_data  <= in_data;
            addr_q     <= sel_cnt[ADDR_W-1:0];
            wr_is_data <= in_is_data;
            wr_last    <= in_last;
            wr_ovf     <= sel_ovf;
            hold_cnt   <= '0;
            if (sel_ovf) ovf_err <= 1'b1;
         end
         if (state == WRITE) begin
            hold_cnt <= hold_cnt + HW'(1);
            // An overflowed word still occupies the write slot but never advances its count.
            if (hold_end && !wr_ovf) begin
               if (wr_is_data) dword_cnt <= dword_cnt + CNT_W'(1);
               else            iword_cnt <= iword_cnt + CNT_W'(1);
            end
         end
         if (state == RUN && cpu_done) load_done <= 1'b1;
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
         if (state == RUN) run_cnt <= run_cnt + RW'(1);
         else              run_cnt <= '0;
         if (state == RUN && !cpu_done && run_to) timeout <= 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader: per-cycle timeline model plus hand-computed session totals.
module tb_cpu_prog_loader;
   localparam int DEPTH = 4;
   localparam int HOLD  = 2;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, in_is_data, in_last;
   logic [31:0] in_data, inst_data;
   logic [9:0]  address;
   logic        cpu_rst, write_instruction, write_data, cpu_done, busy, load_done, ovf_err;
   logic [10:0] iword_cnt, dword_cnt;
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
   logic        timeout;
`endif

   always #5 clk = ~clk;

   cpu_prog_loader #(.ADDR_W(10), .MEM_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(4096)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_is_data(in_is_data), .in_last(in_last), .cpu_rst(cpu_rst),
      .inst_data(inst_data), .address(address), .write_instruction(write_instruction),
      .write_data(write_data), .cpu_done(cpu_done), .busy(busy), .load_done(load_done),
      .ovf_err(ovf_err),
`ifdef CPU_PROG_LOADER_WATCHDOG_EN
      .timeout(timeout),
`endif
      .iword_cnt(iword_cnt), .dword_cnt(dword_cnt));

   // One clock cycle: inputs driven during it and outputs expected during it.
   typedef struct {
      logic        rst, start, valid, is_data, last, done;
      logic [31:0] data;
      bit          chk, chk_addr, chk_dat;
      logic        in_ready, cpu_rst, wi, wd, busy, load_done, ovf;
      logic [9:0]  addr;
      logic [31:0] idat;
      logic [10:0] ic, dc;
   } cyc_t;

   typedef struct { logic [31:0] data; logic is_data; } word_t;
   typedef struct { string nm; logic [31:0] act, exp; } lit_t;

   cyc_t  sched[$];
   word_t wq[$];
   lit_t  lit_q[$];
   cyc_t  cur;
   int    cyc = 0;
   int    checks = 0, errors = 0;
   int    lit_rd = 0;
   int    wi_cyc = 0, wd_cyc = 0, hs_cnt = 0;
   logic [9:0] last_wi_addr = '0;

   function automatic cyc_t blank();
      cyc_t e;
      e.rst = 0; e.start = 0; e.valid = 0; e.is_data = 0; e.last = 0; e.done = 0; e.data = '0;
      e.chk = 0; e.chk_addr = 0; e.chk_dat = 0;
      e.in_ready = 0; e.cpu_rst = 0; e.wi = 0; e.wd = 0; e.busy = 0; e.load_done = 0; e.ovf = 0;
      e.addr = '0; e.idat = '0; e.ic = '0; e.dc = '0;
      return e;
   endfunction

   function automatic cyc_t idle_exp();
      cyc_t e = blank();
      e.chk = 1; e.cpu_rst = 1; e.chk_addr = 1; e.chk_dat = 1;
      return e;
   endfunction

   task automatic add_word(input logic [31:0] d, input logic isd);
      word_t w;
      w.data = d; w.is_data = isd;
      wq.push_back(w);
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      lit_t l;
      l.nm = nm; l.act = act; l.exp = exp;
      lit_q.push_back(l);
   endtask

   // Timeline of a session with in_valid always offered: each word takes one accept cycle
   // plus HOLD write cycles, then RUN until cpu_done, then DONE.
   task automatic gen_session(input int done_delay, input bit start_noise);
      cyc_t e;
      int   ic = 0, dc = 0, sel, n;
      bit   ovf = 0, o;
      n = wq.size();
      e = blank(); e.start = 1; sched.push_back(e);
      for (int k = 0; k < n; k++) begin
         sel = wq[k].is_data ? dc : ic;
         o   = (sel >= DEPTH);
         e = blank();
         e.valid = 1; e.data = wq[k].data; e.is_data = wq[k].is_data; e.last = (k == n - 1);
         e.chk = 1; e.in_ready = 1; e.cpu_rst = 1; e.busy = 1;
         e.chk_addr = 1; e.addr = 10'(sel); e.ic = 11'(ic); e.dc = 11'(dc); e.ovf = ovf;
         sched.push_back(e);
         if (o) ovf = 1;
         for (int h = 0; h < HOLD; h++) begin
            e = blank();
            if (k + 1 < n) begin
               e.valid = 1; e.data = wq[k+1].data; e.is_data = wq[k+1].is_data; e.last = (k + 1 == n - 1);
            end
            e.start = start_noise;
            e.chk = 1; e.cpu_rst = 1; e.busy = 1;
            e.wi = !o && !wq[k].is_data; e.wd = !o && wq[k].is_data;
            e.chk_addr = 1; e.addr = 10'(sel); e.chk_dat = 1; e.idat = wq[k].data;
            e.ic = 11'(ic); e.dc = 11'(dc); e.ovf = ovf;
            sched.push_back(e);
         end
         if (!o) begin
            if (wq[k].is_data) dc++;
            else               ic++;
         end
      end
      for (int r = 0; r <= done_delay; r++) begin
         e = blank();
         e.done = (r == done_delay); e.valid = (r == 1); e.start = start_noise;
         e.chk = 1; e.busy = 1; e.ic = 11'(ic); e.dc = 11'(dc); e.ovf = ovf;
         sched.push_back(e);
      end
      for (int r = 0; r < 3; r++) begin
         e = blank();
         e.valid = (r == 0);
         e.chk = 1; e.load_done = 1; e.ic = 11'(ic); e.dc = 11'(dc); e.ovf = ovf;
         sched.push_back(e);
      end
   endtask

   task automatic run_sched();
      cyc_t e;
      while (sched.size() > 0) begin
         e = sched.pop_front();
         @(posedge clk); #1;
         rst = e.rst; start = e.start; in_valid = e.valid; in_data = e.data;
         in_is_data = e.is_data; in_last = e.last; cpu_done = e.done;
         cur = e;
         cyc++;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (write_instruction === 1'b1) begin
         wi_cyc++;
         last_wi_addr = address;
      end
      if (write_data === 1'b1) wd_cyc++;
      if (in_valid === 1'b1 && in_ready === 1'b1) hs_cnt++;
   end

   // Single compare process: session totals first, then the per-cycle timeline.
   always @(negedge clk) begin
      while (lit_rd < lit_q.size()) begin
         chk(lit_q[lit_rd].nm, lit_q[lit_rd].act, lit_q[lit_rd].exp);
         lit_rd++;
      end
      if (cur.chk) begin
         chk("in_ready",          32'(in_ready),          32'(cur.in_ready));
         chk("cpu_rst",           32'(cpu_rst),           32'(cur.cpu_rst));
         chk("write_instruction", 32'(write_instruction), 32'(cur.wi));
         chk("write_data",        32'(write_data),        32'(cur.wd));
         chk("busy",              32'(busy),              32'(cur.busy));
         chk("load_done",         32'(load_done),         32'(cur.load_done));
         chk("ovf_err",           32'(ovf_err),           32'(cur.ovf));
         chk("iword_cnt",         32'(iword_cnt),         32'(cur.ic));
         chk("dword_cnt",         32'(dword_cnt),         32'(cur.dc));
         if (cur.chk_addr) chk("address",   32'(address), 32'(cur.addr));
         if (cur.chk_dat)  chk("inst_data", inst_data,    cur.idat);
      end
   end

   int b_wi, b_wd, b_hs;

   task automatic snap();
      b_wi = wi_cyc; b_wd = wd_cyc; b_hs = hs_cnt;
   endtask

   initial begin
      cyc_t e;
      rst = 1; start = 0; in_valid = 0; in_data = '0; in_is_data = 0; in_last = 0; cpu_done = 0;
      cur = blank();

      // Reset, then idle with stray valids that must never be acknowledged.
      e = blank(); e.rst = 1; sched.push_back(e);
      e = idle_exp(); e.rst = 1; sched.push_back(e);
      for (int i = 0; i < 10; i++) begin
         e = idle_exp(); e.valid = (i % 3 == 0); e.data = 32'h1234_0000 + 32'(i);
         sched.push_back(e);
      end
      run_sched(); @(negedge clk); #1;
      lit("idle_cpu_rst", 32'(cpu_rst), 32'd1);
      lit("idle_busy", 32'(busy), 32'd0);
      lit("idle_handshakes", 32'(hs_cnt), 32'd0);
      lit("idle_strobes", 32'(wi_cyc + wd_cyc), 32'd0);

      // Three instruction words, last on the third.
      snap(); wq.delete();
      add_word(32'h0420_0000, 0); add_word(32'h2FE0_4022, 0); add_word(32'h07FF_8F5C, 0);
      gen_session(5, 0); run_sched(); @(negedge clk); #1;
      lit("s1_iword_cnt", 32'(iword_cnt), 32'd3);
      lit("s1_dword_cnt", 32'(dword_cnt), 32'd0);
      lit("s1_wi_cycles", 32'(wi_cyc - b_wi), 32'd6);
      lit("s1_wd_cycles", 32'(wd_cyc - b_wd), 32'd0);
      lit("s1_last_addr", 32'(last_wi_addr), 32'd2);
      lit("s1_handshakes", 32'(hs_cnt - b_hs), 32'd3);
      lit("s1_load_done", 32'(load_done), 32'd1);
      lit("s1_cpu_rst", 32'(cpu_rst), 32'd0);

      // Interleaved instruction/data words, start pulses while busy.
      snap(); wq.delete();
      add_word(32'h1111_1111, 0); add_word(32'h0000_0007, 1);
      add_word(32'h2222_2222, 0); add_word(32'h0000_000C, 1);
      gen_session(3, 1); run_sched(); @(negedge clk); #1;
      lit("s2_iword_cnt", 32'(iword_cnt), 32'd2);
      lit("s2_dword_cnt", 32'(dword_cnt), 32'd2);
      lit("s2_wi_cycles", 32'(wi_cyc - b_wi), 32'd4);
      lit("s2_wd_cycles", 32'(wd_cyc - b_wd), 32'd4);
      lit("s2_handshakes", 32'(hs_cnt - b_hs), 32'd4);

      // Six instruction words into a 4-deep memory; cpu_done after 50 RUN cycles.
      snap(); wq.delete();
      for (int i = 0; i < 6; i++) add_word(32'hC0DE_0000 + 32'(i), 0);
      gen_session(50, 0); run_sched(); @(negedge clk); #1;
      lit("s3_iword_cnt", 32'(iword_cnt), 32'd4);
      lit("s3_ovf_err", 32'(ovf_err), 32'd1);
      lit("s3_wi_cycles", 32'(wi_cyc - b_wi), 32'd8);
      lit("s3_last_addr", 32'(last_wi_addr), 32'd3);
      lit("s3_handshakes", 32'(hs_cnt - b_hs), 32'd6);
      lit("s3_load_done", 32'(load_done), 32'd1);

      // Single word with last; cpu_done already high on RUN entry.
      snap(); wq.delete();
      add_word(32'hFEED_BEEF, 1);
      gen_session(0, 0); run_sched(); @(negedge clk); #1;
      lit("s4_dword_cnt", 32'(dword_cnt), 32'd1);
      lit("s4_iword_cnt", 32'(iword_cnt), 32'd0);
      lit("s4_ovf_cleared", 32'(ovf_err), 32'd0);
      lit("s4_handshakes", 32'(hs_cnt - b_hs), 32'd1);

      // Reset during the second hold cycle of a data write.
      snap();
      e = blank(); e.start = 1; sched.push_back(e);
      e = blank(); e.valid = 1; e.data = 32'hA5A5_A5A5; e.is_data = 1; e.last = 1;
      e.chk = 1; e.in_ready = 1; e.cpu_rst = 1; e.busy = 1; e.chk_addr = 1; e.addr = '0;
      sched.push_back(e);
      e = blank(); e.chk = 1; e.cpu_rst = 1; e.busy = 1; e.wd = 1;
      e.chk_addr = 1; e.addr = '0; e.chk_dat = 1; e.idat = 32'hA5A5_A5A5;
      sched.push_back(e);
      e.rst = 1; sched.push_back(e);
      for (int i = 0; i < 4; i++) begin
         e = idle_exp(); e.valid = 1; e.data = 32'h5A5A_0000 + 32'(i); e.last = 1;
         sched.push_back(e);
      end
      run_sched(); @(negedge clk); #1;
      lit("rst_handshakes", 32'(hs_cnt - b_hs), 32'd1);
      lit("rst_wd_cycles", 32'(wd_cyc - b_wd), 32'd2);
      lit("rst_in_ready", 32'(in_ready), 32'd0);
      lit("rst_cpu_rst", 32'(cpu_rst), 32'd1);

      repeat (2) @(negedge clk);
      #1;
      cur.chk = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
